// File: rtl/frame_draw_scheduler_pkg.sv
// frame_draw_scheduler_pkg: FSM state encoding, pixel colours and play-area geometry shared with the game datapath.
package frame_draw_scheduler_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_STEP, S_FETCH, S_WALL, S_DUDE, S_BORDER, S_DONE
  } state_e;
  localparam logic [2:0] WALL_ON  = 3'b111;
  localparam logic [2:0] WALL_OFF = 3'b000;
  localparam logic [2:0] DUDE     = 3'b100;
  localparam logic [2:0] BORDER   = 3'b010;
  localparam int TICK_DIV_DEF = 833333;
  localparam int WALL_W_DEF   = 120;
  localparam int WALL_H_DEF   = 100;
  localparam int X_OFF_DEF    = 20;
  localparam int Y_OFF_DEF    = 10;
  localparam int DUDE_W_DEF   = 4;
  localparam int DUDE_H_DEF   = 6;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: divides clk down to a one-cycle frame tick; counter held at 0 while disabled.
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && cnt_q == LAST;
  // next count: wrap on tick, otherwise increment
  always_comb cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  // counter register, synchronously cleared by reset or disable
  always_ff @(posedge clk) begin
    if (!resetn || !en_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer -- tick, datapath step handshake, then wall/sprite pixel stream to vga_adapter.
// Define DRAW_BORDER_EN to add a play-area outline pass after the sprite.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int WALL_W   = WALL_W_DEF,
  parameter int WALL_H   = WALL_H_DEF,
  parameter int X_OFF    = X_OFF_DEF,
  parameter int Y_OFF    = Y_OFF_DEF,
  parameter int DUDE_W   = DUDE_W_DEF,
  parameter int DUDE_H   = DUDE_H_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ingame_i,
  output logic              step_req_o,
  input  logic              step_done_i,
  output logic [6:0]        wall_addr_o,
  input  logic [WALL_H-1:0] wall_col_i,
  input  logic [6:0]        dude_x_i,
  input  logic [7:0]        dude_y_i,
  output logic [7:0]        vga_x_o,
  output logic [6:0]        vga_y_o,
  output logic [2:0]        vga_colour_o,
  output logic              vga_plot_o,
  output logic              busy_o,
  output logic              overrun_o
);
  localparam logic [6:0] COL_LAST = 7'(WALL_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(WALL_H - 1);
  localparam logic [3:0] I_LAST   = 4'(DUDE_W - 1);
  localparam logic [3:0] J_LAST   = 4'(DUDE_H - 1);
  localparam logic [8:0] XO = 9'(X_OFF);
  localparam logic [8:0] YO = 9'(Y_OFF);
  localparam logic [8:0] WW = 9'(WALL_W);
  localparam logic [8:0] WH = 9'(WALL_H);
`ifdef DRAW_BORDER_EN
  localparam logic [8:0] TW     = 9'(WALL_W + 2);
  localparam logic [8:0] TW2    = 9'(2 * (WALL_W + 2));
  localparam logic [8:0] TW2H   = 9'(2 * (WALL_W + 2) + WALL_H);
  localparam logic [8:0] K_LAST = 9'(2 * (WALL_W + 2) + 2 * WALL_H - 1);
  logic [8:0] k_q, k_d;
`endif
  state_e     state_q, state_d;
  logic [6:0] col_q, col_d, row_q, row_d, dx_q, dx_d;
  logic [7:0] dy_q, dy_d, vga_x_q, vga_x_d;
  logic [3:0] i_q, i_d, j_q, j_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d, overrun_q, overrun_d, tick;
  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .resetn(resetn), .en_i(ingame_i), .tick_o(tick)
  );
  assign step_req_o   = state_q == S_STEP;
  assign busy_o       = !(state_q == S_IDLE || state_q == S_WAIT);
  assign wall_addr_o  = col_q;
  assign vga_x_o      = vga_x_q;
  assign vga_y_o      = vga_y_q;
  assign vga_colour_o = vga_colour_q;
  assign vga_plot_o   = vga_plot_q;
  assign overrun_o    = overrun_q;
  // next state, scan counters and the pixel for the slot being processed this cycle
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    i_d = i_q;
    j_d = j_q;
    dx_d = dx_q;
    dy_d = dy_q;
`ifdef DRAW_BORDER_EN
    k_d = k_q;
`endif
    vga_x_d = vga_x_q;
    vga_y_d = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d = 1'b0;
    overrun_d = overrun_q | (tick & busy_o);
    case (state_q)
      S_IDLE:  state_d = S_WAIT;
      S_WAIT:  state_d = tick ? S_STEP : S_WAIT;
      S_STEP: begin
        if (step_done_i) begin
          state_d = S_FETCH;
          col_d = '0;
          dx_d = dude_x_i;
          dy_d = dude_y_i;
        end
      end
      S_FETCH: begin
        state_d = S_WALL;
        row_d = '0;
      end
      S_WALL: begin
        vga_x_d = 8'(XO + {2'b0, col_q});
        vga_y_d = 7'(YO + {2'b0, row_q});
        vga_colour_d = wall_col_i[row_q] ? WALL_ON : WALL_OFF;
        vga_plot_d = 1'b1;
        row_d = row_q + 7'd1;
        if (row_q == ROW_LAST) begin
          state_d = col_q == COL_LAST ? S_DUDE : S_FETCH;
          col_d = col_q == COL_LAST ? col_q : col_q + 7'd1;
          i_d = '0;
          j_d = '0;
        end
      end
      S_DUDE: begin
        vga_x_d = 8'(XO + {2'b0, dx_q} + {5'b0, i_q});
        vga_y_d = 7'(YO + {1'b0, dy_q} + {5'b0, j_q});
        vga_colour_d = DUDE;
        vga_plot_d = ({2'b0, dx_q} + {5'b0, i_q} < WW) && ({1'b0, dy_q} + {5'b0, j_q} < WH);
        j_d = j_q + 4'd1;
        if (j_q == J_LAST) begin
          j_d = '0;
          i_d = i_q + 4'd1;
`ifdef DRAW_BORDER_EN
          k_d = '0;
          if (i_q == I_LAST) state_d = S_BORDER;
`else
          if (i_q == I_LAST) state_d = S_DONE;
`endif
        end
      end
`ifdef DRAW_BORDER_EN
      S_BORDER: begin
        vga_x_d = k_q < TW ? 8'(XO - 9'd1 + k_q) : k_q < TW2 ? 8'(XO - 9'd1 + k_q - TW) :
                  k_q < TW2H ? 8'(XO - 9'd1) : 8'(XO + WW);
        vga_y_d = k_q < TW ? 7'(YO - 9'd1) : k_q < TW2 ? 7'(YO + WH) :
                  k_q < TW2H ? 7'(YO + k_q - TW2) : 7'(YO + k_q - TW2H);
        vga_colour_d = BORDER;
        vga_plot_d = 1'b1;
        k_d = k_q + 9'd1;
        if (k_q == K_LAST) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (!ingame_i) begin
      state_d = S_IDLE;
      vga_plot_d = 1'b0;
    end
  end
  // state, counters, latched sprite position and registered pixel outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      col_q <= '0;
      row_q <= '0;
      i_q <= '0;
      j_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
`ifdef DRAW_BORDER_EN
      k_q <= '0;
`endif
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_colour_q <= '0;
      vga_plot_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      i_q <= i_d;
      j_q <= j_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
`ifdef DRAW_BORDER_EN
      k_q <= k_d;
`endif
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q <= vga_plot_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
